// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared definitions for the iterative multiply/divide unit:
//            operation encodings, FSM state type and a counter-width helper.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Number of bits needed to hold the values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_if
// Purpose  : Handshake and data bundle between the EX stage (master) and the
//            iterative multiply/divide unit (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 annul_i;
    logic [1:0]           op_i;
    logic [WIDTH-1:0]     opa_i;
    logic [WIDTH-1:0]     opb_i;
    logic                 busy_o;
    logic                 stallreq_o;
    logic                 valid_o;
    logic [2*WIDTH-1:0]   result_o;
    logic                 div_zero_o;

    modport master (
        output start_i, annul_i, op_i, opa_i, opb_i,
        input  busy_o, stallreq_o, valid_o, result_o, div_zero_o
    );

    modport slave (
        input  start_i, annul_i, op_i, opa_i, opb_i,
        output busy_o, stallreq_o, valid_o, result_o, div_zero_o
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_absneg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_absneg
// Purpose  : Conditional two's-complement negate of a 2*WIDTH vector, either
//            as one wide number or as two independent WIDTH-bit halves.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_absneg #(
    parameter int WIDTH = 32
) (
    input  wire logic [2*WIDTH-1:0] val_i,
    input  wire logic               wide_i,    // 1: treat val_i as one number, negate on neg_lo_i
    input  wire logic               neg_hi_i,  // split mode: negate upper half
    input  wire logic               neg_lo_i,  // split mode: negate lower half; wide mode: negate all
    output logic      [2*WIDTH-1:0] val_o
);
    logic [2*WIDTH-1:0] w_wide;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;

    // Both flavours are built in parallel; wide_i picks the one in use.
    always_comb begin
        w_wide = neg_lo_i ? -val_i : val_i;
        w_hi   = neg_hi_i ? -val_i[2*WIDTH-1:WIDTH] : val_i[2*WIDTH-1:WIDTH];
        w_lo   = neg_lo_i ? -val_i[WIDTH-1:0]       : val_i[WIDTH-1:0];
        val_o  = wide_i ? w_wide : {w_hi, w_lo};
    end
endmodule
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter
// Purpose  : WIDTH-generic iterative multiply / divide unit (one bit per
//            cycle). Signed ops are done on magnitudes and sign-fixed at end.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic clk,
    input  wire logic resetn,
    muldiv_if.slave   bus
);
    localparam int CW = clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;          // multiplicand / dividend (magnitude after PREP)
    logic [WIDTH-1:0]  b_q, b_d;          // multiplier / divisor (magnitude after PREP)
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [W2:0]       acc_q, acc_d;      // mult: {carry, hi, lo}; div: {rem[W:0], quotient}
    logic              neg_hi_q, neg_hi_d; // negate remainder in FIX
    logic              neg_lo_q, neg_lo_d; // negate product / quotient in FIX
    logic              dzp_q, dzp_d;       // divide-by-zero flag of the op in flight
    logic [W2-1:0]     res_q, res_d;       // last delivered result
    logic              dz_q, dz_d;         // last delivered divide-by-zero flag

    logic              w_accept, w_fire, w_busy;
    logic              w_signed, w_is_div, w_b_zero, w_last;
    logic [W2-1:0]     w_mag, w_fixed;
    logic [WIDTH:0]    w_mul_sum, w_shift, w_trial;
    logic [W2:0]       w_mul_next, w_div_next;

    assign w_accept = (state_q == S_IDLE) && bus.start_i && !bus.annul_i;
    assign w_fire   = (state_q == S_DONE) && !bus.annul_i;
    assign w_busy   = (state_q != S_IDLE);
    assign w_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign w_is_div = (op_q == OP_DIV)  || (op_q == OP_DIVU);
    assign w_b_zero = (b_q == '0);
    assign w_last   = (cnt_q == CW'(WIDTH - 1));

    // Shift-add step, LSB of the multiplier first; the top bit keeps the carry.
    assign w_mul_sum  = acc_q[W2:WIDTH] + (acc_q[0] ? {1'b0, a_q} : '0);
    assign w_mul_next = {1'b0, w_mul_sum, acc_q[WIDTH-1:1]};

    // Restoring-division step: shift in the next dividend bit, trial-subtract.
    assign w_shift    = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, b_q};
    assign w_div_next = w_trial[WIDTH] ? {w_shift, acc_q[WIDTH-2:0], 1'b0}
                                       : {w_trial, acc_q[WIDTH-2:0], 1'b1};

    // Magnitudes of the captured operands (used in PREP).
    muldiv_absneg #(.WIDTH(WIDTH)) u_prep_abs (
        .val_i    ({a_q, b_q}),
        .wide_i   (1'b0),
        .neg_hi_i (w_signed && a_q[WIDTH-1]),
        .neg_lo_i (w_signed && b_q[WIDTH-1]),
        .val_o    (w_mag)
    );

    // Sign restoration of the raw result (used in FIX).
    muldiv_absneg #(.WIDTH(WIDTH)) u_fix_neg (
        .val_i    (acc_q[W2-1:0]),
        .wide_i   (!w_is_div),
        .neg_hi_i (neg_hi_q),
        .neg_lo_i (neg_lo_q),
        .val_o    (w_fixed)
    );

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            neg_hi_q <= 1'b0;
            neg_lo_q <= 1'b0;
            dzp_q    <= 1'b0;
            res_q    <= '0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            neg_hi_q <= neg_hi_d;
            neg_lo_q <= neg_lo_d;
            dzp_q    <= dzp_d;
            res_q    <= res_d;
            dz_q     <= dz_d;
        end
    end

    // Next-state logic; annul from any busy state returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_accept) state_d = S_PREP;
            S_PREP:  state_d = (w_is_div && w_b_zero) ? S_DONE : S_CALC;
            S_CALC:  if (w_last) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (w_busy && bus.annul_i) begin
            state_d = S_IDLE;
        end
    end

    // Datapath next values: capture, magnitude prep, iterate, sign fix, deliver.
    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        neg_hi_d = neg_hi_q;
        neg_lo_d = neg_lo_q;
        dzp_d    = dzp_q;
        res_d    = res_q;
        dz_d     = dz_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d  = bus.op_i;
                    a_d   = bus.opa_i;
                    b_d   = bus.opb_i;
                    cnt_d = '0;
                    dzp_d = 1'b0;
                end
            end
            S_PREP: begin
                a_d      = w_mag[W2-1:WIDTH];
                b_d      = w_mag[WIDTH-1:0];
                neg_lo_d = w_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_hi_d = w_signed && w_is_div && a_q[WIDTH-1];
                if (w_is_div && w_b_zero) begin
                    // Raw dividend goes out as the remainder, quotient is all ones.
                    acc_d = {1'b0, a_q, {WIDTH{1'b1}}};
                    dzp_d = 1'b1;
                end else if (w_is_div) begin
                    acc_d = {{(WIDTH + 1){1'b0}}, w_mag[W2-1:WIDTH]};
                end else begin
                    acc_d = {{(WIDTH + 1){1'b0}}, w_mag[WIDTH-1:0]};
                end
            end
            S_CALC: begin
                acc_d = w_is_div ? w_div_next : w_mul_next;
                cnt_d = w_last ? '0 : cnt_q + 1'b1;
            end
            S_FIX: begin
                acc_d = {1'b0, w_fixed};
            end
            S_DONE: begin
                if (w_fire) begin
                    res_d = acc_q[W2-1:0];
                    dz_d  = dzp_q;
                end
            end
            default: ;
        endcase
    end

    // During DONE the fresh result is forwarded so it is valid with valid_o.
    assign bus.busy_o     = w_busy;
    assign bus.valid_o    = w_fire;
    assign bus.stallreq_o = resetn && (w_accept || (w_busy && !w_fire));
    assign bus.result_o   = w_fire ? acc_q[W2-1:0] : res_q;
    assign bus.div_zero_o = w_fire ? dzp_q : dz_q;

endmodule
`default_nettype wire

// File: doc/muldiv_iter.md
# muldiv_iter

Parametrised iterative multiply/divide unit for the EX stage; it replaces the fixed 32-bit divider and the separate multiplier with one shared, WIDTH-generic datapath. It accepts an operation under a start/busy handshake, computes one bit per cycle, and returns a 2·WIDTH {hi, lo} result with a one-cycle valid pulse. EX stalls the pipeline on stallreq_o and writes the result toward HI/LO.

## Interface
- WIDTH, 32: operand width in bits (≥ 4, even).
- clk  in  1  clock, all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- start_i  in  1  request a new operation; sampled only in IDLE.
- annul_i  in  1  abort the in-flight operation; priority over start_i.
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; captured at accept.
- opa_i  in  WIDTH  multiplicand or dividend; captured at accept.
- opb_i  in  WIDTH  multiplier or divisor; captured at accept.
- busy_o  out  1  high from the cycle after accept until IDLE is re-entered.
- stallreq_o  out  1  equals accept | (busy_o & ~valid_o); combinational.
- valid_o  out  1  one-cycle pulse; result_o is valid in that cycle.
- result_o  out  2·WIDTH  {hi, lo}. For a multiply: the product. For a divide: {remainder, quotient}. Held until the next accept.
- div_zero_o  out  1  divisor was 0; qualified by valid_o and held with result_o.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- Accept condition: state == IDLE & start_i & ~annul_i. On accept:
  - latch op, opa and opb;
  - clear the iteration counter;
  - go to PREP.
- PREP:
  - Signed ops (MULT, DIV): record each operand sign, replace each operand by its magnitude, and record the result signs.
  - Unsigned ops: pass operands through unchanged.
  - DIV/DIVU with opb == 0: go directly to DONE. result_o = {opa as captured, all ones}, div_zero_o = 1.
  - Otherwise go to CALC.
- CALC runs exactly WIDTH iterations; the counter counts 0 … WIDTH-1.
  - Multiply: shift-add, LSB first. Accumulator is 2·WIDTH+1 bits; the extra bit absorbs the carry.
  - Divide: restoring. Remainder register is WIDTH+1 bits. Trial-subtract; if non-negative, keep the result and shift in quotient bit 1, else shift in 0.
- FIX, signed ops only:
  - Product negated if the operand signs differ.
  - Quotient negated if sign(opa) ^ sign(opb).
  - Remainder takes the sign of the dividend.
  - All results truncated to their field width.
  - MIN ÷ −1 needs no special case: it yields quotient MIN, remainder 0.
  - Unsigned ops pass through FIX unchanged.
- DONE: drive valid_o = 1, update result_o and div_zero_o, then go to IDLE.
- annul_i in any non-IDLE state:
  - next state is IDLE;
  - no valid_o pulse;
  - result_o and div_zero_o keep their previous values.
- start_i while busy is ignored; there is no queue.

## Timing
- Accept at edge T:
  - normal op: valid_o is high in cycle T+WIDTH+3 (PREP 1, CALC WIDTH, FIX 1, DONE 1);
  - divide by zero: valid_o is high in cycle T+2.
- A new operation can be accepted in the cycle after DONE. Back-to-back throughput is WIDTH+4 cycles per op.
- Reset (resetn = 0 at an edge), including mid-operation:
  - state = IDLE, busy_o = 0, valid_o = 0;
  - result_o = 0, div_zero_o = 0;
  - counter = 0;
  - stallreq_o = 0 while resetn is low.
- Operands are not re-sampled after accept: changes to op_i/opa_i/opb_i during busy have no effect.
- annul_i and valid_o in the same cycle (state DONE): annul wins; valid_o is suppressed and result_o is not updated.

## Structure
- Package muldiv_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum;
  - the counter-width function clog2(WIDTH).
- Single module. A small combinational sub-module, muldiv_absneg (conditional two's-complement negate, parametrised width), is instantiated once for PREP magnitudes and once for FIX negation.

## Test plan
All scenarios use WIDTH = 32.
- MULT −3 × 7 (opa = 0xFFFFFFFD) → valid at T+35; result_o = 0xFFFFFFFF_FFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → result_o = 0xFFFFFFFE_00000001.
- DIV −7 ÷ 2 → lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1). DIV 0x80000000 ÷ −1 → lo = 0x80000000, hi = 0.
- DIVU 100 ÷ 0 → valid at T+2; div_zero_o = 1; result_o = {0x00000064, 0xFFFFFFFF}.
- Abort and restart:
  - annul_i at T+10 of a DIVU → busy_o low at T+11, no valid_o, result_o unchanged;
  - start_i at T+11 is accepted normally.
- Mid-operation reset and ignored start:
  - resetn low at T+20 → all outputs 0 at the next edge;
  - start_i asserted during busy → ignored, and the original result is unaffected.
